pipe_stage_hs: RTL and testbench

//  Parametrised elastic pipeline register; generalises the fixed ID/EX latch.

---
 rtl/pipe_stage_hs.sv | 103 ++++++++++
 tb/tb_pipe_stage_hs.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// Elastic valid/ready pipeline register with optional 2-entry skid buffer, flush-to-bubble and stall counter.
// Latency: 1 cycle from input transfer to out_valid/out_data (both driven straight from flops).
// Backpressure: SKID=1 uses a registered in_ready (!skid_full) so out_ready has no comb path; SKID=0 in_ready = !full || out_ready.
module pipe_stage_hs #(
   parameter int unsigned        DATA_W = 32,
   parameter logic [DATA_W-1:0]  BUBBLE = '0,
   parameter bit                 SKID   = 1'b1,
   parameter int unsigned        CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   // main entry (M) drives the outputs; skid entry (S) only fills behind a stalled M
   logic              m_vld_q, m_vld_d;
   logic [DATA_W-1:0] m_dat_q, m_dat_d;
   logic              s_vld_q, s_vld_d;
   logic [DATA_W-1:0] s_dat_q, s_dat_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              in_xfer;
   logic              out_xfer;

   // Acceptance: blocked during reset and flush; otherwise depends on skid configuration
   always_comb begin
      in_ready = 1'b0;
      if (!rst && !flush) begin
         if (SKID) begin
            in_ready = !s_vld_q;
         end else begin
            in_ready = !m_vld_q || out_ready;
         end
      end
   end

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = m_vld_q && out_ready;

   // Entry update: flush wins; M refills from S first (order), then from input; S catches input behind a stalled M
   always_comb begin
      m_vld_d = m_vld_q;
      m_dat_d = m_dat_q;
      s_vld_d = s_vld_q;
      s_dat_d = s_dat_q;
      if (flush) begin
         m_vld_d = 1'b0;
         m_dat_d = BUBBLE;
         s_vld_d = 1'b0;
      end else if (out_xfer || !m_vld_q) begin
         if (s_vld_q) begin
            m_vld_d = 1'b1;
            m_dat_d = s_dat_q;
            s_vld_d = 1'b0;
         end else if (in_xfer) begin
            m_vld_d = 1'b1;
            m_dat_d = in_data;
         end else begin
            m_vld_d = 1'b0;
            m_dat_d = BUBBLE;
         end
      end else if (in_xfer) begin
         s_vld_d = 1'b1;
         s_dat_d = in_data;
      end
   end

   // Saturating count of cycles where the consumer refuses a valid payload; flush leaves it alone
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (m_vld_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State registers; reset discards held payloads exactly like flush and also clears the counter
   always_ff @(posedge clk) begin
      if (rst) begin
         m_vld_q     <= 1'b0;
         m_dat_q     <= BUBBLE;
         s_vld_q     <= 1'b0;
         s_dat_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         m_vld_q     <= m_vld_d;
         m_dat_q     <= m_dat_d;
         s_vld_q     <= s_vld_d;
         s_dat_q     <= s_dat_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = m_vld_q;
   assign out_data  = m_dat_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: one SKID=1 and one SKID=0 instance share stimulus, each checked every cycle
// against a queue model (capacity 2 or 1) built from the handshake rules.
// Directed scenarios first (reset, streaming, skid stall, flush, saturation, SKID=0 replace), then random traffic.
module tb_pipe_stage_hs;

   localparam logic [15:0] BUB = 16'hDEAD;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [15:0] in_data;
   logic        in_ready0, in_ready1, out_valid0, out_valid1;
   logic [15:0] out_data0, out_data1;
   logic [3:0]  stall0, stall1;

   int n_err = 0;
   int n_chk = 0;

   // model state: held entries per instance, index 0 = head
   logic [15:0] mq [2][2];
   int          mcnt [2];
   int          mstall [2];
   logic        er [2];
   int unsigned seq;
   logic        acc;

   always #5 clk = ~clk;

   pipe_stage_hs #(.DATA_W(16), .BUBBLE(BUB), .SKID(1'b0), .CNT_W(4)) u0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .stall_cnt(stall0));

   pipe_stage_hs #(.DATA_W(16), .BUBBLE(BUB), .SKID(1'b1), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .stall_cnt(stall1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one clock: drive inputs, check in_ready, advance model at the edge, check registered outputs
   task automatic step(input logic r, input logic f, input logic iv, input logic [15:0] id,
                       input logic ordy, output logic accepted1);
      rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (r || f) er[k] = 1'b0;
         else if (k == 1) er[k] = (mcnt[k] < 2);
         else er[k] = (mcnt[k] == 0) || ordy;
      end
      chk("in_ready0", in_ready0, er[0]);
      chk("in_ready1", in_ready1, er[1]);
      accepted1 = iv && er[1];
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            mcnt[k] = 0;
            mstall[k] = 0;
         end else begin
            if (mcnt[k] > 0 && !ordy && mstall[k] < 15) mstall[k]++;
            if (f) begin
               mcnt[k] = 0;
            end else begin
               if (mcnt[k] > 0 && ordy) begin
                  mq[k][0] = mq[k][1];
                  mcnt[k]--;
               end
               if (iv && er[k]) begin
                  mq[k][mcnt[k]] = id;
                  mcnt[k]++;
               end
            end
         end
      end
      #1;
      chk("out_valid0", out_valid0, mcnt[0] > 0);
      chk("out_valid1", out_valid1, mcnt[1] > 0);
      chk("out_data0", out_data0, (mcnt[0] > 0) ? mq[0][0] : BUB);
      chk("out_data1", out_data1, (mcnt[1] > 0) ? mq[1][0] : BUB);
      chk("stall0", stall0, mstall[0]);
      chk("stall1", stall1, mstall[1]);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0;
         mstall[k] = 0;
         mq[k][0] = '0;
         mq[k][1] = '0;
      end

      // reset held two cycles with a pending producer, then release
      step(1, 0, 1, 16'h0077, 1, acc);
      step(1, 0, 1, 16'h0077, 1, acc);
      chk("rst_data1", out_data1, BUB);
      chk("rst_stall1", stall1, 0);
      step(0, 0, 0, 16'h0000, 1, acc);

      // back-to-back streaming 1..8
      for (int i = 1; i <= 8; i++) step(0, 0, 1, 16'(i), 1, acc);
      step(0, 0, 0, 16'h0000, 1, acc);
      step(0, 0, 0, 16'h0000, 1, acc);

      // skid: A lands, consumer stalls, B goes to S, C waits, then drain in order
      step(0, 0, 1, 16'h000A, 1, acc);
      step(0, 0, 1, 16'h000B, 0, acc);
      step(0, 0, 1, 16'h000C, 0, acc);
      chk("skid_full_rdy1", in_ready1, 0);
      step(0, 0, 1, 16'h000C, 0, acc);
      step(0, 0, 1, 16'h000C, 1, acc);
      step(0, 0, 1, 16'h000C, 1, acc);
      step(0, 0, 0, 16'h0000, 1, acc);
      step(0, 0, 0, 16'h0000, 1, acc);
      chk("skid_stall1", stall1, 3);

      // flush with both entries occupied and a new payload offered
      step(1, 0, 0, 16'h0000, 1, acc);
      step(0, 0, 1, 16'h0011, 0, acc);
      step(0, 0, 1, 16'h0022, 0, acc);
      step(0, 1, 1, 16'h0033, 0, acc);
      chk("flush_vld1", out_valid1, 0);
      chk("flush_data1", out_data1, BUB);
      step(0, 0, 0, 16'h0000, 1, acc);

      // stall counter saturation, not cleared by flush
      step(1, 0, 0, 16'h0000, 1, acc);
      step(0, 0, 1, 16'h0005, 0, acc);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0000, 0, acc);
      chk("sat1", stall1, 15);
      step(0, 1, 0, 16'h0000, 0, acc);
      chk("sat_flush1", stall1, 15);
      chk("sat_flush0", stall0, 15);

      // SKID=0: full entry replaced in the same cycle it is taken
      step(1, 0, 0, 16'h0000, 1, acc);
      step(0, 0, 1, 16'h0055, 0, acc);
      step(0, 0, 1, 16'h0066, 1, acc);
      chk("replace_vld0", out_valid0, 1);
      chk("replace_dat0", out_data0, 16'h0066);

      // random traffic with an ordered producer sequence
      seq = 16'h0100;
      for (int i = 0; i < 1000; i++) begin
         step(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 10) < 7,
              16'(seq), ($urandom % 10) < 6, acc);
         if (acc) seq++;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
